// File: rtl/parcnn_pkg.sv
// ParCNN shared network parameters, bundle types and rect1 packing helper.
// Widths follow the *_BITWIDTH MSB-index convention (width = value + 1).
package parcnn_pkg;

  localparam int SCREEN_X_BITWIDTH     = 5;
  localparam int SCREEN_Y_BITWIDTH     = 5;
  localparam int CAMERA_PIXEL_BITWIDTH = 8;
  localparam int RECT_OUT_BITWIDTH     = 23;
  localparam int SCREEN_MAX            = 35;
  localparam int TILE                  = 4;
  localparam int GRID                  = 8;

  localparam int SX_W   = SCREEN_X_BITWIDTH + 1;
  localparam int SY_W   = SCREEN_Y_BITWIDTH + 1;
  localparam int PIX_W  = CAMERA_PIXEL_BITWIDTH + 1;
  localparam int RECT_W = RECT_OUT_BITWIDTH + 1;
  localparam int ACC_W  = 13;

  typedef logic signed [ACC_W-1:0] score_t;

  localparam score_t SCORE_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  typedef struct packed {
    logic [2:0] tx;
    logic [2:0] ty;
  } tile_t;

  // {x_min, y_min, x_max, y_max}, each a 6-bit screen coordinate
  function automatic logic [RECT_W-1:0] pack_rect(input tile_t t);
    return {1'b0, t.tx, 2'b00,
            1'b0, t.ty, 2'b00,
            1'b0, t.tx, 2'b11,
            1'b0, t.ty, 2'b11};
  endfunction

endpackage

// File: rtl/parcnn_tile_max_tracker.sv
// Best-tile tracker: keeps the highest tile sum of the frame (earliest wins
// ties) and latches its rectangle at frame end.
module tile_max_tracker
  import parcnn_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              tile_done,
  input  score_t            tile_sum,
  input  tile_t             tile_id,
  input  logic              frame_end,
  output logic [RECT_W-1:0] rect
);

  score_t            best_score_q, best_score_d;
  tile_t             best_tile_q, best_tile_d;
  logic [RECT_W-1:0] rect_q, rect_d;

  always_comb begin
    best_score_d = best_score_q;
    best_tile_d  = best_tile_q;
    rect_d       = rect_q;
    if (frame_end) begin
      rect_d       = pack_rect(best_tile_q);
      best_score_d = SCORE_MIN;
      best_tile_d  = '0;
    end else if (tile_done && (tile_sum > best_score_q)) begin
      best_score_d = tile_sum;
      best_tile_d  = tile_id;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      best_score_q <= SCORE_MIN;
      best_tile_q  <= '0;
      rect_q       <= '0;
    end else begin
      best_score_q <= best_score_d;
      best_tile_q  <= best_tile_d;
      rect_q       <= rect_d;
    end
  end

  assign rect = rect_q;

endmodule

// File: rtl/parcnn_top.sv
// ParCNN front end: per-column tile accumulators over the 32x32 active
// window, feeding the best-tile tracker that drives rect1.
module parcnn_top
  import parcnn_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic [SX_W-1:0]   scree_x_pos,
  input  logic [SY_W-1:0]   screen_y_pos,
  input  logic [PIX_W-1:0]  test_pixel,
  output logic [RECT_W-1:0] rect1
);

  logic [GRID-1:0][ACC_W-1:0] acc_q, acc_d;

  logic   active;
  logic   tile_done;
  logic   frame_end;
  tile_t  tile_id;
  score_t pix_ext;
  score_t acc_cur;
  score_t tile_sum;

  always_comb begin
    // bit 5 clear means the coordinate lies in 0..31
    active    = !scree_x_pos[5] && !screen_y_pos[5];
    tile_done = active && (scree_x_pos[1:0] == 2'b11)
                       && (screen_y_pos[1:0] == 2'b11);
    frame_end = (scree_x_pos == SX_W'(SCREEN_MAX))
             && (screen_y_pos == SY_W'(SCREEN_MAX));
    tile_id.tx = scree_x_pos[4:2];
    tile_id.ty = screen_y_pos[4:2];
    pix_ext  = score_t'($signed(test_pixel));
    acc_cur  = score_t'(acc_q[tile_id.tx]);
    tile_sum = acc_cur + pix_ext;
    acc_d    = acc_q;
    if (active) begin
      acc_d[tile_id.tx] = tile_done ? '0 : tile_sum;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  tile_max_tracker u_tracker (
    .clock     (clock),
    .reset     (reset),
    .tile_done (tile_done),
    .tile_sum  (tile_sum),
    .tile_id   (tile_id),
    .frame_end (frame_end),
    .rect      (rect1)
  );

endmodule

// File: tb/tb_parcnn_top.sv
// Bench for parcnn_top: table-driven frame patterns, a reset-in-frame
// sequence, and random frames checked against a tile-sum reference model.
module tb_parcnn_top;

  logic        clock = 1'b0;
  logic        reset;
  logic [5:0]  sx;
  logic [5:0]  sy;
  logic [8:0]  px;
  logic [23:0] rect1;

  logic [8:0]  pix [36][36];
  int          total = 0;
  int          bad   = 0;
  logic [23:0] prev_exp;

  typedef struct {
    int          kind;
    int          bx;
    int          by;
    logic [23:0] exp;
  } vec_t;

  vec_t tbl [4];

  parcnn_top dut (
    .clock        (clock),
    .reset        (reset),
    .scree_x_pos  (sx),
    .screen_y_pos (sy),
    .test_pixel   (px),
    .rect1        (rect1)
  );

  always #5 clock = ~clock;

  function automatic logic [23:0] mk(input int tx, input int ty);
    logic [5:0] a, b, c, d;
    a = 6'(tx * 4);
    b = 6'(ty * 4);
    c = 6'(tx * 4 + 3);
    d = 6'(ty * 4 + 3);
    return {a, b, c, d};
  endfunction

  task automatic chk(input string nm, input logic [23:0] act,
                     input logic [23:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  // 0: const 0.25; 1: zero + bright tile; 2: -0.25 + zero tile;
  // 3: bright only outside the active window
  task automatic fill(input int kind, input int bx, input int by);
    for (int y = 0; y < 36; y++) begin
      for (int x = 0; x < 36; x++) begin
        case (kind)
          0: pix[y][x] = 9'h040;
          1: pix[y][x] = (x / 4 == bx && y / 4 == by && x < 32 && y < 32)
                         ? 9'h0FF : 9'h000;
          2: pix[y][x] = (x / 4 == bx && y / 4 == by && x < 32 && y < 32)
                         ? 9'h000 : 9'h1C0;
          default: pix[y][x] = (x >= 32 || y >= 32) ? 9'h0FF : 9'h000;
        endcase
      end
    end
  endtask

  // Reference: whole-tile sums, best = highest, earliest in raster on ties
  function automatic logic [23:0] model_rect();
    int s [8][8];
    int best, bx, by;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) s[i][j] = 0;
    for (int y = 0; y < 32; y++)
      for (int x = 0; x < 32; x++)
        s[y / 4][x / 4] += int'($signed(pix[y][x]));
    best = s[0][0];
    bx = 0;
    by = 0;
    for (int ty = 0; ty < 8; ty++)
      for (int tx = 0; tx < 8; tx++)
        if (s[ty][tx] > best) begin
          best = s[ty][tx];
          bx = tx;
          by = ty;
        end
    return mk(bx, by);
  endfunction

  task automatic step(input int x, input int y, input logic [8:0] p,
                      input logic r);
    sx    = 6'(x);
    sy    = 6'(y);
    px    = p;
    reset = r;
    @(posedge clock);
    #1;
  endtask

  task automatic run_frame(input int rx, input int ry,
                           input logic [23:0] exp, input string nm);
    logic r;
    for (int y = 0; y < 36; y++) begin
      for (int x = 0; x < 36; x++) begin
        r = (x == rx) && (y == ry);
        step(x, y, pix[y][x], r);
        if (r) begin
          chk({nm, "_rst"}, rect1, 24'h0);
          prev_exp = 24'h0;
        end
        if (x == 17 && y == 17) chk({nm, "_hold"}, rect1, prev_exp);
        if (x == 34 && y == 35) chk({nm, "_pre"}, rect1, prev_exp);
        if (x == 35 && y == 35) begin
          chk(nm, rect1, exp);
          prev_exp = exp;
        end
      end
    end
  endtask

  initial begin
    tbl[0] = '{kind: 0, bx: 0, by: 0, exp: {6'd0,  6'd0,  6'd3,  6'd3}};
    tbl[1] = '{kind: 1, bx: 5, by: 2, exp: {6'd20, 6'd8,  6'd23, 6'd11}};
    tbl[2] = '{kind: 2, bx: 7, by: 7, exp: {6'd28, 6'd28, 6'd31, 6'd31}};
    tbl[3] = '{kind: 3, bx: 0, by: 0, exp: {6'd0,  6'd0,  6'd3,  6'd3}};

    step(0, 0, 9'h0FF, 1'b1);
    step(0, 0, 9'h0FF, 1'b1);
    chk("reset_state", rect1, 24'h0);

    // scan a full frame with reset held: output must stay cleared
    for (int y = 0; y < 36; y++) begin
      for (int x = 0; x < 36; x++) begin
        step(x, y, 9'h040, 1'b1);
        if (x == 35) chk($sformatf("rst_held_y%0d", y), rect1, 24'h0);
      end
    end
    prev_exp = 24'h0;

    for (int i = 0; i < 4; i++) begin
      fill(tbl[i].kind, tbl[i].bx, tbl[i].by);
      run_frame(-1, -1, tbl[i].exp, $sformatf("vec%0d", i));
    end

    fill(1, 1, 1);
    run_frame(-1, -1, mk(1, 1), "seq_f1");
    // reset at (10,10): first tile completed afterwards is (0,2), all zero
    fill(1, 2, 0);
    run_frame(10, 10, mk(0, 2), "seq_f2");
    fill(1, 6, 3);
    run_frame(-1, -1, mk(6, 3), "seq_f3");

    for (int f = 0; f < 8; f++) begin
      for (int y = 0; y < 36; y++) begin
        for (int x = 0; x < 36; x++) begin
          if (f % 2 == 0) pix[y][x] = 9'($urandom);
          else pix[y][x] = 9'($urandom_range(0, 1));
        end
      end
      if (f == 5) begin
        for (int y = 0; y < 32; y++)
          for (int x = 0; x < 32; x++) pix[y][x] = 9'h100;
      end
      run_frame(-1, -1, model_rect(), $sformatf("rand%0d", f));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
